// File: rtl/mem_stall_ctrl.sv
// mem_stall_ctrl: data-memory stall controller at the EX/MEM -> MEM boundary.
// Runs a req/ack handshake with a variable-latency data memory. While an access
// is outstanding it holds memStallOut high to freeze the pipeline buffers.
// It also keeps a stall-cycle counter and sticky protocol-error flags.
// Optional feature: define MEM_TIMEOUT_EN to abort a WAIT after TIMEOUT cycles
// without ack (returns ABORT_DATA on reads and sets timeoutOut).
module mem_stall_ctrl #(
  parameter int unsigned TIMEOUT    = 255,
  parameter logic [31:0] ABORT_DATA = 32'hDEADBEEF
) (
  input  logic        clockIn,
  input  logic        reset,
  input  logic        memReadIn,
  input  logic        memWriteIn,
  input  logic [31:0] addrIn,
  input  logic [31:0] writeDataIn,
  output logic        memStallOut,
  output logic [31:0] readDataOut,
  output logic        memReqOut,
  output logic        memWeOut,
  output logic [31:0] memAddrOut,
  output logic [31:0] memWDataOut,
  input  logic        memAckIn,
  input  logic [31:0] memRDataIn,
  output logic [31:0] stallCountOut,
  output logic        errOut,
  output logic        timeoutOut
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t state;
  state_t state_nxt;

  logic acc;
  logic tmo_hit;

  assign acc = memReadIn | memWriteIn;

`ifdef MEM_TIMEOUT_EN
  logic [31:0] wait_cnt;

  // Abort fires on the last allowed WAIT cycle; a same-cycle ack takes priority.
  assign tmo_hit = (state == S_WAIT) && !memAckIn && (wait_cnt == 32'(TIMEOUT - 1));

  // Wait counter: zero in the first WAIT cycle, counts each WAIT cycle after.
  always_ff @(posedge clockIn or posedge reset) begin
    if (reset) begin
      wait_cnt <= '0;
    end else if (state != S_WAIT) begin
      wait_cnt <= '0;
    end else begin
      wait_cnt <= wait_cnt + 32'd1;
    end
  end

  // Sticky timeout flag.
  always_ff @(posedge clockIn or posedge reset) begin
    if (reset) begin
      timeoutOut <= 1'b0;
    end else if (tmo_hit) begin
      timeoutOut <= 1'b1;
    end
  end
`else
  assign tmo_hit    = 1'b0;
  assign timeoutOut = 1'b0;
`endif

  // State register.
  always_ff @(posedge clockIn or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (acc) state_nxt = S_WAIT;
      S_WAIT:  if (memAckIn || tmo_hit) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Stall output; gated by reset so it drops asynchronously with the FSM.
  always_comb begin
    memStallOut = 1'b0;
    if (!reset) begin
      memStallOut = ((state == S_IDLE) && acc) || (state == S_WAIT);
    end
  end

  // Request/datapath registers, stall counter and sticky error flag.
  always_ff @(posedge clockIn or posedge reset) begin
    if (reset) begin
      memReqOut     <= 1'b0;
      memWeOut      <= 1'b0;
      memAddrOut    <= '0;
      memWDataOut   <= '0;
      readDataOut   <= '0;
      stallCountOut <= '0;
      errOut        <= 1'b0;
    end else begin
      if (memStallOut) begin
        stallCountOut <= stallCountOut + 32'd1;
      end
      case (state)
        S_IDLE: begin
          if (acc) begin
            memAddrOut  <= {addrIn[31:2], 2'b00};
            memWDataOut <= writeDataIn;
            memWeOut    <= memWriteIn;
            memReqOut   <= 1'b1;
          end
          if ((memReadIn && memWriteIn) || memAckIn) begin
            errOut <= 1'b1;
          end
        end
        S_WAIT: begin
          if (memAckIn) begin
            memReqOut <= 1'b0;
            if (!memWeOut) begin
              readDataOut <= memRDataIn;
            end
          end else if (tmo_hit) begin
            memReqOut <= 1'b0;
`ifdef MEM_TIMEOUT_EN
            if (!memWeOut) begin
              readDataOut <= ABORT_DATA;
            end
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stall_ctrl.sv
// Self-checking bench for mem_stall_ctrl. Expected per-access results are
// pushed to a scoreboard queue when the access is driven and popped when the
// DUT reaches its non-stalled DONE cycle.
module tb_mem_stall_ctrl;

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned TMO    = 4;
  localparam bit          TMO_EN = 1'b1;
`else
  localparam int unsigned TMO    = 255;
  localparam bit          TMO_EN = 1'b0;
`endif
  localparam logic [31:0] ABORT = 32'hDEADBEEF;

  logic        clockIn = 1'b0;
  logic        reset;
  logic        memReadIn;
  logic        memWriteIn;
  logic [31:0] addrIn;
  logic [31:0] writeDataIn;
  logic        memStallOut;
  logic [31:0] readDataOut;
  logic        memReqOut;
  logic        memWeOut;
  logic [31:0] memAddrOut;
  logic [31:0] memWDataOut;
  logic        memAckIn;
  logic [31:0] memRDataIn;
  logic [31:0] stallCountOut;
  logic        errOut;
  logic        timeoutOut;

  mem_stall_ctrl #(.TIMEOUT(TMO), .ABORT_DATA(ABORT)) dut (
    .clockIn(clockIn), .reset(reset),
    .memReadIn(memReadIn), .memWriteIn(memWriteIn),
    .addrIn(addrIn), .writeDataIn(writeDataIn),
    .memStallOut(memStallOut), .readDataOut(readDataOut),
    .memReqOut(memReqOut), .memWeOut(memWeOut),
    .memAddrOut(memAddrOut), .memWDataOut(memWDataOut),
    .memAckIn(memAckIn), .memRDataIn(memRDataIn),
    .stallCountOut(stallCountOut), .errOut(errOut), .timeoutOut(timeoutOut)
  );

  always #5 clockIn = ~clockIn;

  typedef struct {
    int unsigned stalls;
    logic [31:0] rdata;
    logic [31:0] count;
    logic        err;
    logic        tmo;
  } exp_t;

  exp_t sb[$];

  int unsigned checks = 0;
  int unsigned errors = 0;

  logic [31:0] m_rdata = '0;
  logic [31:0] m_count = '0;
  logic        m_err   = 1'b0;
  logic        m_tmo   = 1'b0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic model_reset();
    m_rdata = '0;
    m_count = '0;
    m_err   = 1'b0;
    m_tmo   = 1'b0;
    sb.delete();
  endtask

  // Drive one access; ack arrives n cycles after memReqOut first rises.
  task automatic access(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input int unsigned n,
                        input logic [31:0] rdata);
    exp_t e;
    exp_t got;
    int unsigned stalls = 0;
    bit done = 1'b0;
    bit timed;
    timed = TMO_EN && (n >= TMO);
    e.stalls = timed ? TMO + 1 : n + 2;
    if (timed) begin
      m_tmo = 1'b1;
      if (!wr) m_rdata = ABORT;
    end else if (!wr) begin
      m_rdata = rdata;
    end
    m_count = m_count + 32'(e.stalls);
    if (rd && wr) m_err = 1'b1;
    e.rdata = m_rdata;
    e.count = m_count;
    e.err   = m_err;
    e.tmo   = m_tmo;
    sb.push_back(e);

    memReadIn   = rd;
    memWriteIn  = wr;
    addrIn      = addr;
    writeDataIn = wdata;
    for (int c = 0; c < 64 && !done; c++) begin
      memAckIn   = (c == int'(n + 1));
      memRDataIn = memAckIn ? rdata : $urandom();
      @(negedge clockIn);
      if (c == 0) begin
        check("stall_first", {31'b0, memStallOut}, 32'd1);
        check("req_first", {31'b0, memReqOut}, 32'd0);
      end
      if (c == 1) begin
        check("req_up", {31'b0, memReqOut}, 32'd1);
        check("we", {31'b0, memWeOut}, {31'b0, wr});
        check("addr", memAddrOut, {addr[31:2], 2'b00});
        check("wdata", memWDataOut, wdata);
      end
      if (memStallOut) begin
        stalls++;
      end else begin
        done = 1'b1;
        got = sb.pop_front();
        check("stalls", stalls, got.stalls);
        check("rdata", readDataOut, got.rdata);
        check("count", stallCountOut, got.count);
        check("err", {31'b0, errOut}, {31'b0, got.err});
        check("tmo", {31'b0, timeoutOut}, {31'b0, got.tmo});
        check("req_done", {31'b0, memReqOut}, 32'd0);
      end
      @(posedge clockIn);
      #1;
    end
    memAckIn   = 1'b0;
    memReadIn  = 1'b0;
    memWriteIn = 1'b0;
    if (!done) check("done_reached", 32'd0, 32'd1);
  endtask

  initial begin
    reset       = 1'b1;
    memReadIn   = 1'b0;
    memWriteIn  = 1'b0;
    addrIn      = '0;
    writeDataIn = '0;
    memAckIn    = 1'b0;
    memRDataIn  = '0;
    @(negedge clockIn);
    check("rst_stall", {31'b0, memStallOut}, 32'd0);
    check("rst_req", {31'b0, memReqOut}, 32'd0);
    check("rst_rdata", readDataOut, 32'd0);
    check("rst_count", stallCountOut, 32'd0);
    check("rst_err", {31'b0, errOut}, 32'd0);
    @(posedge clockIn);
    #1;
    reset = 1'b0;
    @(posedge clockIn);
    #1;

    // Basic read, zero-latency ack; then a 5-cycle write.
    access(1'b1, 1'b0, 32'h0000_1003, 32'h0, 0, 32'h1234_5678);
    access(1'b0, 1'b1, 32'h0000_2000, 32'hCAFE_F00D, 5, 32'h5555_AAAA);

    // Two back-to-back loads: exactly one non-stalled (DONE) cycle between windows.
    access(1'b1, 1'b0, 32'h0000_0010, 32'h0, 0, 32'hA1A1_A1A1);
    access(1'b1, 1'b0, 32'h0000_0014, 32'h0, 0, 32'hB2B2_B2B2);

    // Read and write together: issued as a write, error raised.
    access(1'b1, 1'b1, 32'h0000_0FFF, 32'h0BAD_0BAD, 1, 32'h7777_7777);

    // Reset in WAIT cycle 3 of an access that would otherwise run long.
    memReadIn   = 1'b1;
    addrIn      = 32'h0000_3000;
    writeDataIn = 32'h1111_2222;
    for (int c = 0; c < 3; c++) begin
      @(posedge clockIn);
      #1;
    end
    #2;
    reset = 1'b1;
    #1;
    check("midrst_req", {31'b0, memReqOut}, 32'd0);
    check("midrst_stall", {31'b0, memStallOut}, 32'd0);
    check("midrst_count", stallCountOut, 32'd0);
    check("midrst_rdata", readDataOut, 32'd0);
    check("midrst_addr", memAddrOut, 32'd0);
    check("midrst_err", {31'b0, errOut}, 32'd0);
    memReadIn = 1'b0;
    model_reset();
    @(posedge clockIn);
    #1;
    reset = 1'b0;

    // Late/spurious ack in IDLE: flags error, no state change.
    memAckIn   = 1'b1;
    memRDataIn = 32'hFACE_FACE;
    @(negedge clockIn);
    check("spur_stall", {31'b0, memStallOut}, 32'd0);
    @(posedge clockIn);
    #1;
    memAckIn = 1'b0;
    m_err    = 1'b1;
    @(negedge clockIn);
    check("spur_err", {31'b0, errOut}, 32'd1);
    check("spur_req", {31'b0, memReqOut}, 32'd0);
    check("spur_stall2", {31'b0, memStallOut}, 32'd0);
    check("spur_rdata", readDataOut, 32'd0);
    @(posedge clockIn);
    #1;

    // Access still works after the spurious ack.
    access(1'b1, 1'b0, 32'h0000_4002, 32'h0, 2, 32'h0F0F_0F0F);

`ifdef MEM_TIMEOUT_EN
    // Never-acked read aborts; ack coinciding with the last WAIT cycle wins.
    access(1'b1, 1'b0, 32'h0000_5000, 32'h0, 1000, 32'h0);
    access(1'b1, 1'b0, 32'h0000_5004, 32'h0, TMO - 1, 32'h3C3C_3C3C);
`endif

    // Random mix of single reads/writes with varying latency.
    for (int i = 0; i < 8; i++) begin
      logic wr;
      wr = 1'($urandom_range(0, 1));
      access(!wr, wr, $urandom(), $urandom(), $urandom_range(0, 6), $urandom());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
